// File: rtl/gate_response_checker_if.sv
// Bus bundle for gate_response_checker: run control, stimulus,
// gate response and run status grouped behind master/slave views.
interface gate_response_checker_if #(
   parameter int ERR_W = 4
);
   logic             start;
   logic [2:0]       gate_sel;
   logic             A;
   logic             B;
   logic             Q;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;
   logic [3:0]       fail_vec;

   // checker side: drives stimulus and status
   modport master (
      input  start,
      input  gate_sel,
      input  Q,
      output A,
      output B,
      output busy,
      output done,
      output pass,
      output err_count,
      output fail_vec
   );

   // environment side: requests runs and returns the gate output
   modport slave (
      output start,
      output gate_sel,
      output Q,
      input  A,
      input  B,
      input  busy,
      input  done,
      input  pass,
      input  err_count,
      input  fail_vec
   );
endinterface

// File: rtl/gate_response_checker.sv
// On-board truth-table checker for 2-input gates: walks {A,B}=00..11,
// samples Q after a settle window and reports mismatches.
// Optional macro GATE_CHK_STOP_ON_FAIL_EN ends a run at the first mismatch.
module gate_response_checker #(
   parameter int SETTLE_CYCLES = 4,
   parameter int LOOPS         = 1,
   parameter int ERR_W         = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   gate_response_checker_if.master bus
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;

   localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
   localparam logic [LW-1:0]    LOOP_LAST   = LW'(LOOPS - 1);
   localparam logic [ERR_W-1:0] ERR_MAX     = '1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [2:0]       r_sel;
   logic [1:0]       r_vec;
   logic [SW-1:0]    r_settle;
   logic [LW-1:0]    r_loop;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [ERR_W-1:0] r_err;
   logic [3:0]       r_fail;

   logic             w_a;
   logic             w_b;
   logic             w_exp;
   logic             w_sample;
   logic             w_miss;
   logic             w_seq_end;
   logic             w_finish;
   logic [ERR_W-1:0] w_err_nxt;
   logic [3:0]       w_fail_nxt;

   assign w_a = r_vec[1];
   assign w_b = r_vec[0];

   // reference model of the selected gate on the current vector
   always_comb begin
      w_exp = 1'b0;
      unique case (r_sel)
         3'd0: w_exp = w_a & w_b;
         3'd1: w_exp = w_a | w_b;
         3'd2: w_exp = w_a ^ w_b;
         3'd3: w_exp = ~(w_a & w_b);
         3'd4: w_exp = ~(w_a | w_b);
         3'd5: w_exp = ~(w_a ^ w_b);
         3'd6: w_exp = w_a;
         3'd7: w_exp = ~w_a;
      endcase
   end

   assign w_sample  = (r_state == S_RUN) && (r_settle == '0);
   assign w_miss    = w_sample && (bus.Q != w_exp);
   assign w_seq_end = w_sample && (r_vec == 2'd3) && (r_loop == LOOP_LAST);

   // next error tally and sticky vector flags for the sample edge
   always_comb begin
      w_err_nxt  = r_err;
      w_fail_nxt = r_fail;
      if (w_miss) begin
         if (r_err != ERR_MAX) begin
            w_err_nxt = r_err + ERR_W'(1);
         end
         w_fail_nxt = r_fail | (4'b0001 << r_vec);
      end
   end

`ifdef GATE_CHK_STOP_ON_FAIL_EN
   assign w_finish = w_seq_end || w_miss;
`else
   assign w_finish = w_seq_end;
`endif

   // run sequencer: IDLE -> RUN (vector walk) -> DONE -> IDLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_sel    <= 3'd0;
         r_vec    <= 2'd0;
         r_settle <= '0;
         r_loop   <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_pass   <= 1'b0;
         r_err    <= '0;
         r_fail   <= 4'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state  <= S_RUN;
                  r_sel    <= bus.gate_sel;
                  r_err    <= '0;
                  r_fail   <= 4'd0;
                  r_pass   <= 1'b0;
                  r_vec    <= 2'd0;
                  r_busy   <= 1'b1;
                  r_settle <= SETTLE_LOAD;
                  r_loop   <= '0;
               end
            end
            S_RUN: begin
               if (w_sample) begin
                  r_err  <= w_err_nxt;
                  r_fail <= w_fail_nxt;
                  if (w_finish) begin
                     r_state  <= S_DONE;
                     r_vec    <= 2'd0;
                     r_busy   <= 1'b0;
                     r_done   <= 1'b1;
                     r_pass   <= (w_err_nxt == '0);
                     r_settle <= '0;
                     r_loop   <= '0;
                  end else begin
                     r_vec    <= r_vec + 2'd1;
                     r_settle <= SETTLE_LOAD;
                     if (r_vec == 2'd3) begin
                        r_loop <= r_loop + LW'(1);
                     end
                  end
               end else begin
                  r_settle <= r_settle - SW'(1);
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.A         = w_a;
   assign bus.B         = w_b;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.pass      = r_pass;
   assign bus.err_count = r_err;
   assign bus.fail_vec  = r_fail;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: one default instance
// plus a two-loop, 2-bit-counter instance for saturation.
module tb_gate_response_checker;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   int   trace [0:63];

   gate_response_checker_if #(.ERR_W(4)) bus1 ();
   gate_response_checker_if #(.ERR_W(2)) bus2 ();

   gate_response_checker #(
      .SETTLE_CYCLES(4),
      .LOOPS(1),
      .ERR_W(4)
   ) dut1 (
      .clk(clk),
      .rst(rst),
      .bus(bus1)
   );

   gate_response_checker #(
      .SETTLE_CYCLES(4),
      .LOOPS(2),
      .ERR_W(2)
   ) dut2 (
      .clk(clk),
      .rst(rst),
      .bus(bus2)
   );

   // gate model on dut1 is a correct OR; dut2 sees Q stuck at 0
   assign bus1.Q = bus1.A | bus1.B;
   assign bus2.Q = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic run1(input logic [2:0] sel, output int n);
      bus1.gate_sel = sel;
      bus1.start    = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      n = 0;
      while (bus1.busy && n < 60) begin
         trace[n] = {30'd0, bus1.A, bus1.B};
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus1.start = 1'b0;
      bus1.gate_sel = 3'd0;
      bus2.start = 1'b0;
      bus2.gate_sel = 3'd0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({bus1.A, bus1.B, bus1.busy, bus1.done, bus1.pass} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctl: got %b required 00000",
                  {bus1.A, bus1.B, bus1.busy, bus1.done, bus1.pass});
      end
      checks++;
      if ({bus1.err_count, bus1.fail_vec} !== 8'h00) begin
         errors++;
         $display("FAIL reset_cnt: got %h required 00",
                  {bus1.err_count, bus1.fail_vec});
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus2.busy, bus2.done, bus2.err_count, bus2.fail_vec} !== 8'h00) begin
         errors++;
         $display("FAIL reset_dut2: got %h required 00",
                  {bus2.busy, bus2.done, bus2.err_count, bus2.fail_vec});
      end
   endtask

   task automatic test_or_pass;
      int n;
      int bad;
      run1(3'd1, n);
      checks++;
      if (n !== 16) begin
         errors++;
         $display("FAIL or_busy_len: got %0d required 16", n);
      end
      bad = 0;
      for (int k = 0; k < 16; k++) begin
         if (trace[k] != k / 4) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL or_vec_order: got %0d bad steps required 0", bad);
      end
      checks++;
      if ({bus1.done, bus1.pass, bus1.A, bus1.B} !== 4'b1100) begin
         errors++;
         $display("FAIL or_done: got %b required 1100",
                  {bus1.done, bus1.pass, bus1.A, bus1.B});
      end
      checks++;
      if ({bus1.err_count, bus1.fail_vec} !== 8'h00) begin
         errors++;
         $display("FAIL or_errs: got %h required 00",
                  {bus1.err_count, bus1.fail_vec});
      end
      @(negedge clk);
      checks++;
      if ({bus1.done, bus1.pass} !== 2'b01) begin
         errors++;
         $display("FAIL or_done_pulse: got %b required 01",
                  {bus1.done, bus1.pass});
      end
   endtask

   task automatic test_and_fail;
      int n;
      int hi;
      int req_n;
      logic [3:0] req_err;
      logic [3:0] req_fv;
      int req_hi;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
      req_n = 8;
      req_err = 4'd1;
      req_fv = 4'b0010;
      req_hi = 0;
`else
      req_n = 16;
      req_err = 4'd2;
      req_fv = 4'b0110;
      req_hi = 1;
`endif
      @(negedge clk);
      run1(3'd0, n);
      hi = 0;
      for (int k = 0; k < n; k++) begin
         if (trace[k] >= 2) hi = 1;
      end
      checks++;
      if (n !== req_n) begin
         errors++;
         $display("FAIL and_busy_len: got %0d required %0d", n, req_n);
      end
      checks++;
      if (hi !== req_hi) begin
         errors++;
         $display("FAIL and_upper_vecs: got %0d required %0d", hi, req_hi);
      end
      checks++;
      if ({bus1.done, bus1.pass} !== 2'b10) begin
         errors++;
         $display("FAIL and_done: got %b required 10",
                  {bus1.done, bus1.pass});
      end
      checks++;
      if (bus1.err_count !== req_err) begin
         errors++;
         $display("FAIL and_err_count: got %0d required %0d",
                  bus1.err_count, req_err);
      end
      checks++;
      if (bus1.fail_vec !== req_fv) begin
         errors++;
         $display("FAIL and_fail_vec: got %b required %b",
                  bus1.fail_vec, req_fv);
      end
      @(negedge clk);
      checks++;
      if ({bus1.done, bus1.err_count, bus1.fail_vec} !== {1'b0, req_err, req_fv}) begin
         errors++;
         $display("FAIL and_hold: got %h required %h",
                  {bus1.done, bus1.err_count, bus1.fail_vec},
                  {1'b0, req_err, req_fv});
      end
   endtask

   task automatic test_saturate;
      int n;
      int req_n;
      logic [1:0] req_err;
      logic [3:0] req_fv;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
      req_n = 4;
      req_err = 2'd1;
      req_fv = 4'b0001;
`else
      req_n = 32;
      req_err = 2'b11;
      req_fv = 4'b0111;
`endif
      bus2.gate_sel = 3'd3;
      bus2.start = 1'b1;
      @(negedge clk);
      bus2.start = 1'b0;
      n = 0;
      while (bus2.busy && n < 60) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n !== req_n) begin
         errors++;
         $display("FAIL sat_busy_len: got %0d required %0d", n, req_n);
      end
      checks++;
      if ({bus2.done, bus2.pass, bus2.err_count} !== {2'b10, req_err}) begin
         errors++;
         $display("FAIL sat_status: got %b required %b",
                  {bus2.done, bus2.pass, bus2.err_count}, {2'b10, req_err});
      end
      checks++;
      if (bus2.fail_vec !== req_fv) begin
         errors++;
         $display("FAIL sat_fail_vec: got %b required %b",
                  bus2.fail_vec, req_fv);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run;
      int n;
      logic [3:0] req_err;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
      bus1.gate_sel = 3'd2;
      req_err = 4'd0;
`else
      bus1.gate_sel = 3'd0;
      req_err = 4'd1;
`endif
      bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      for (n = 0; n < 9; n++) @(negedge clk);
      checks++;
      if ({bus1.busy, bus1.A, bus1.B, bus1.err_count} !== {3'b110, req_err}) begin
         errors++;
         $display("FAIL mid_pre_rst: got %b required %b",
                  {bus1.busy, bus1.A, bus1.B, bus1.err_count},
                  {3'b110, req_err});
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus1.A, bus1.B, bus1.busy, bus1.done, bus1.pass,
           bus1.err_count, bus1.fail_vec} !== 13'd0) begin
         errors++;
         $display("FAIL mid_async_rst: got %h required 0",
                  {bus1.A, bus1.B, bus1.busy, bus1.done, bus1.pass,
                   bus1.err_count, bus1.fail_vec});
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus1.busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_idle: busy got %b required 0", bus1.busy);
      end
      run1(3'd1, n);
      checks++;
      if ({n[7:0], bus1.done, bus1.pass, bus1.fail_vec} !== {8'd16, 2'b11, 4'd0}) begin
         errors++;
         $display("FAIL mid_rerun: got n=%0d done=%b pass=%b fv=%b required 16 1 1 0000",
                  n, bus1.done, bus1.pass, bus1.fail_vec);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int n;
      int dones;
      bus1.gate_sel = 3'd1;
      bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      n = 0;
      dones = 0;
      while (bus1.busy && n < 60) begin
         if (n == 5) begin
            bus1.start = 1'b1;
            bus1.gate_sel = 3'd0;
         end else begin
            bus1.start = 1'b0;
         end
         n++;
         @(negedge clk);
      end
      bus1.start = 1'b0;
      checks++;
      if (n !== 16) begin
         errors++;
         $display("FAIL b2b_busy_len: got %0d required 16", n);
      end
      checks++;
      if ({bus1.pass, bus1.err_count} !== {1'b1, 4'd0}) begin
         errors++;
         $display("FAIL b2b_latched_sel: got pass=%b err=%0d required 1 0",
                  bus1.pass, bus1.err_count);
      end
      for (int k = 0; k < 4; k++) begin
         if (bus1.done) dones++;
         @(negedge clk);
      end
      checks++;
      if (dones !== 1) begin
         errors++;
         $display("FAIL b2b_done_count: got %0d required 1", dones);
      end
      checks++;
      if (bus1.busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_restart: busy got %b required 0", bus1.busy);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      test_reset();
      test_or_pass();
      test_and_fail();
      test_saturate();
      test_reset_mid_run();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
Synthesizable self-checking harness for the 2-input basic gates. It drives the gate under test through the full truth table in the order {A,B} = 00, 01, 10, 11. After a settle window it samples the gate's Q and compares it against the expected function chosen by gate_sel. It reports mismatch count, per-vector fail flags and a pass/done status, so gate designs can be checked on-board without a simulator bench.

Parameters:
SETTLE_CYCLES, 4, clock cycles each vector is held before Q is sampled; must be >= 1
LOOPS, 1, number of complete truth-table passes per run; must be >= 1
ERR_W, 4, width of the saturating mismatch counter

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  reset, asynchronous, active-high
start  in  1  level-sampled run request; honoured only in IDLE
gate_sel  in  3  expected function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 BUF (Q=A), 7 INV (Q=~A)
A  out  1  stimulus to gate input A (registered)
B  out  1  stimulus to gate input B (registered)
Q  in  1  gate output under check (combinational from A/B)
busy  out  1  high while vectors are being applied
done  out  1  one-cycle pulse at end of run
pass  out  1  1 when the last run had zero mismatches; valid from done, held until next start
err_count  out  ERR_W  mismatches in the last run, saturating at all-ones
fail_vec  out  4  sticky; bit i set if vector {A,B}=i mismatched in any loop

Behaviour:
- Reset (async, immediate, including mid-run): state=IDLE. A=0, B=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0. Internal vector, settle and loop counters cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when start=1 at a rising edge. On that edge:
  - gate_sel is latched; it is ignored for the rest of the run.
  - err_count, fail_vec and pass are cleared.
  - A/B are set to vector 0, busy=1, settle counter = SETTLE_CYCLES-1, loop counter = 0.
- RUN:
  - Each vector is held exactly SETTLE_CYCLES cycles.
  - On the edge where the settle counter is 0, Q is compared to expected(latched gate_sel, A, B).
  - On a mismatch: err_count increments unless it is already all-ones, and fail_vec[{A,B}] is set.
  - On that same edge A/B advance to the next vector and the settle counter reloads.
  - After vector 3: if loop counter < LOOPS-1, the loop counter increments and the sequence wraps to vector 0. Otherwise go to DONE.
- RUN -> DONE edge: A=B=0, busy=0, done=1, pass=(final err_count==0). The final err_count includes a mismatch on the last vector.
- DONE -> IDLE on the next edge unconditionally. done returns to 0; pass, err_count and fail_vec hold.
- Latency: busy is high for exactly 4*SETTLE_CYCLES*LOOPS cycles. done rises on the edge where busy falls.
- start while busy=1 or in DONE is ignored, with no restart. start held high continuously re-arms a new run on the edge after DONE.
- Expected value is computed combinationally from latched gate_sel and registered A/B. Q is treated as already settled at the sample edge; there is no synchronizer.

Optional Feature:
Macro GATE_CHK_STOP_ON_FAIL_EN.
- Defined: the first mismatch ends the run early. The mismatch is still counted (err_count=1) and flagged in fail_vec. The next state is DONE with A=B=0, busy=0, done=1, pass=0, and the remaining vectors and loops are skipped.
- Undefined: every vector of every loop is always applied and checked, as above.

Test Plan:
- Correct OR model on Q, gate_sel=1, SETTLE_CYCLES=4, LOOPS=1, start one cycle -> busy high 16 cycles; A/B step 00,01,10,11 every 4 cycles; done one-cycle pulse; pass=1, err_count=0, fail_vec=4'b0000.
- OR model on Q, gate_sel=0 (AND) -> err_count=2, fail_vec=4'b0110, pass=0, busy 16 cycles.
- Q tied 0, gate_sel=3 (NAND), ERR_W=2, LOOPS=2 -> 6 mismatches, err_count saturates at 2'b11, fail_vec=4'b0111, busy 32 cycles, pass=0.
- rst asserted mid-run at vector 2 with err_count=1 -> all outputs 0 immediately, state IDLE; a new start gives a clean full run.
- start pulsed again while busy; gate_sel changed mid-run -> run is not restarted, checking uses the originally latched gate_sel, single done pulse.
- GATE_CHK_STOP_ON_FAIL_EN defined, OR model, gate_sel=0, SETTLE_CYCLES=4 -> mismatch at vector 01; done at cycle 8; err_count=1, fail_vec=4'b0010, pass=0, vectors 10/11 never driven.
